// File: rtl/tlb_unit_pkg.sv
// Shared TLB types, INVTLB op codes and the entry match helpers.
package cpuDefine;

  localparam int TLBNUMSIZE = 4;
  localparam int TLBNUM     = 1 << TLBNUMSIZE;

  localparam logic [5:0] PS_4K = 6'd12;

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } PhytranItem;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    PhytranItem  phytran0;
    PhytranItem  phytran1;
  } TlbEntry;

  // Compare-relevant subset of an entry; the translation halves never feed a match.
  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
  } TlbKey;

  typedef enum logic [4:0] {
    INV_ALL0     = 5'd0,
    INV_ALL1     = 5'd1,
    INV_G1       = 5'd2,
    INV_G0       = 5'd3,
    INV_ASID     = 5'd4,
    INV_ASID_VA  = 5'd5,
    INV_GASID_VA = 5'd6
  } inv_op_e;

  function automatic logic vppn_match(TlbKey k, logic [18:0] vppn);
    return (k.ps == PS_4K) ? (k.vppn == vppn) : (k.vppn[18:9] == vppn[18:9]);
  endfunction

  function automatic logic lookup_hit(TlbKey k, logic [18:0] vppn, logic [9:0] asid);
    return k.e && (k.g || (k.asid == asid)) && vppn_match(k, vppn);
  endfunction

  function automatic logic inv_hit(TlbKey k, logic [4:0] op, logic [9:0] asid,
                                   logic [18:0] vppn);
    logic asid_eq;
    logic va_eq;
    asid_eq = (k.asid == asid);
    va_eq   = vppn_match(k, vppn);
    case (op)
      INV_ALL0, INV_ALL1: return 1'b1;
      INV_G1:             return k.g;
      INV_G0:             return !k.g;
      INV_ASID:           return !k.g && asid_eq;
      INV_ASID_VA:        return !k.g && asid_eq && va_eq;
      INV_GASID_VA:       return (k.g || asid_eq) && va_eq;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tlb_unit_if.sv
// Lookup, CSR read/write and INVTLB signal bundle between the core and the TLB.
interface tlb_unit_if import cpuDefine::*; #(
  parameter int TLBNUMSIZE = 4
) ();

  logic                  s0_req;
  logic [31:0]           s0_va;
  logic [9:0]            s0_asid;
  logic                  s0_found;
  logic [TLBNUMSIZE-1:0] s0_index;
  logic [5:0]            s0_ps;
  PhytranItem            s0_phytran;

  logic                  s1_req;
  logic                  s1_srch;
  logic [31:0]           s1_va;
  logic [9:0]            s1_asid;
  logic                  s1_found;
  logic [5:0]            s1_ps;
  PhytranItem            s1_phytran;
  logic                  s1e;
  logic [TLBNUMSIZE-1:0] s1_index;
  logic                  s1_ne;

  logic                  rd_req;
  logic [TLBNUMSIZE-1:0] r_index;
  logic                  re;
  logic [5:0]            r_ps;
  logic [9:0]            r_asid;
  logic                  r_ne;
  logic                  r_g;
  logic [18:0]           r_vppn;
  PhytranItem            r_phytran0;
  PhytranItem            r_phytran1;

  logic                  we;
  logic [TLBNUMSIZE-1:0] w_index;
  logic [5:0]            w_ps;
  logic                  w_ne;
  logic [9:0]            w_asid;
  logic [18:0]           w_vppn;
  logic                  w_g;
  PhytranItem            w_phytran0;
  PhytranItem            w_phytran1;

  logic                  inv_en;
  logic [4:0]            inv_op;
  logic [9:0]            f_asid;
  logic [18:0]           f_va;
  logic                  inv_err;

  modport master (
    output s0_req, s0_va, s0_asid,
    input  s0_found, s0_index, s0_ps, s0_phytran,
    output s1_req, s1_srch, s1_va, s1_asid,
    input  s1_found, s1_ps, s1_phytran, s1e, s1_index, s1_ne,
    output rd_req, r_index,
    input  re, r_ps, r_asid, r_ne, r_g, r_vppn, r_phytran0, r_phytran1,
    output we, w_index, w_ps, w_ne, w_asid, w_vppn, w_g, w_phytran0, w_phytran1,
    output inv_en, inv_op, f_asid, f_va,
    input  inv_err
  );

  modport slave (
    input  s0_req, s0_va, s0_asid,
    output s0_found, s0_index, s0_ps, s0_phytran,
    input  s1_req, s1_srch, s1_va, s1_asid,
    output s1_found, s1_ps, s1_phytran, s1e, s1_index, s1_ne,
    input  rd_req, r_index,
    output re, r_ps, r_asid, r_ne, r_g, r_vppn, r_phytran0, r_phytran1,
    input  we, w_index, w_ps, w_ne, w_asid, w_vppn, w_g, w_phytran0, w_phytran1,
    input  inv_en, inv_op, f_asid, f_va,
    output inv_err
  );

endinterface

// File: rtl/tlb_unit_match.sv
// One lookup compare port: per-entry hit vector and lowest-index priority encode.
module tlb_match import cpuDefine::*; #(
  parameter int TLBNUM     = 16,
  parameter int TLBNUMSIZE = 4
) (
  input  TlbKey [TLBNUM-1:0]     keys,
  input  logic [18:0]            vppn,
  input  logic [9:0]             asid,
  output logic [TLBNUM-1:0]      hit_vec,
  output logic [TLBNUMSIZE-1:0]  index
);

  always_comb begin
    hit_vec = '0;
    index   = '0;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      hit_vec[i] = lookup_hit(keys[i], vppn, asid);
    end
    // Scan downward so the lowest hitting index is the last one written.
    for (int unsigned i = TLBNUM; i > 0; i--) begin
      if (hit_vec[i-1]) index = TLBNUMSIZE'(i - 1);
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// Flop-based TLB: two registered lookup ports, TLBRD/TLBWR/TLBFILL and INVTLB.
module tlb_unit import cpuDefine::*; #(
  parameter int TLBNUM     = 16,
  parameter int TLBNUMSIZE = 4
) (
  input  logic        clk,
  input  logic        reset,
  tlb_unit_if.slave   bus
);

  TlbEntry [TLBNUM-1:0]   tlb;
  TlbEntry [TLBNUM-1:0]   tlb_next;
  TlbKey   [TLBNUM-1:0]   keys;

  logic [TLBNUM-1:0]      s0_hit_vec, s1_hit_vec;
  logic [TLBNUMSIZE-1:0]  s0_idx, s1_idx;
  logic                   s0_hit, s1_hit;
  TlbEntry                s0_ent, s1_ent, r_ent;
  PhytranItem             s0_half, s1_half;

  always_comb begin
    keys = '0;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      keys[i].e    = tlb[i].e;
      keys[i].vppn = tlb[i].vppn;
      keys[i].ps   = tlb[i].ps;
      keys[i].g    = tlb[i].g;
      keys[i].asid = tlb[i].asid;
    end
  end

  tlb_match #(.TLBNUM(TLBNUM), .TLBNUMSIZE(TLBNUMSIZE)) u_match0 (
    .keys    (keys),
    .vppn    (bus.s0_va[31:13]),
    .asid    (bus.s0_asid),
    .hit_vec (s0_hit_vec),
    .index   (s0_idx)
  );

  tlb_match #(.TLBNUM(TLBNUM), .TLBNUMSIZE(TLBNUMSIZE)) u_match1 (
    .keys    (keys),
    .vppn    (bus.s1_va[31:13]),
    .asid    (bus.s1_asid),
    .hit_vec (s1_hit_vec),
    .index   (s1_idx)
  );

  assign s0_hit  = |s0_hit_vec;
  assign s1_hit  = |s1_hit_vec;
  assign s0_ent  = tlb[s0_idx];
  assign s1_ent  = tlb[s1_idx];
  assign r_ent   = tlb[bus.r_index];
  assign s0_half = ((s0_ent.ps == PS_4K) ? bus.s0_va[12] : bus.s0_va[21]) ?
                   s0_ent.phytran1 : s0_ent.phytran0;
  assign s1_half = ((s1_ent.ps == PS_4K) ? bus.s1_va[12] : bus.s1_va[21]) ?
                   s1_ent.phytran1 : s1_ent.phytran0;

  // Invalidate against old contents first, then the write lands on top so it always survives.
  always_comb begin
    tlb_next = tlb;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      if (bus.inv_en && inv_hit(keys[i], bus.inv_op, bus.f_asid, bus.f_va))
        tlb_next[i].e = 1'b0;
      if (bus.we && (bus.w_index == TLBNUMSIZE'(i))) begin
        tlb_next[i].e        = ~bus.w_ne;
        tlb_next[i].vppn     = bus.w_vppn;
        tlb_next[i].ps       = bus.w_ps;
        tlb_next[i].g        = bus.w_g;
        tlb_next[i].asid     = bus.w_asid;
        tlb_next[i].phytran0 = bus.w_phytran0;
        tlb_next[i].phytran1 = bus.w_phytran1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tlb            <= '0;
      bus.s0_found   <= 1'b0;
      bus.s0_index   <= '0;
      bus.s0_ps      <= '0;
      bus.s0_phytran <= '0;
      bus.s1_found   <= 1'b0;
      bus.s1_index   <= '0;
      bus.s1_ps      <= '0;
      bus.s1_phytran <= '0;
      bus.s1e        <= 1'b0;
      bus.s1_ne      <= 1'b1;
      bus.re         <= 1'b0;
      bus.r_ps       <= '0;
      bus.r_asid     <= '0;
      bus.r_ne       <= 1'b1;
      bus.r_g        <= 1'b0;
      bus.r_vppn     <= '0;
      bus.r_phytran0 <= '0;
      bus.r_phytran1 <= '0;
      bus.inv_err    <= 1'b0;
    end else begin
      tlb <= tlb_next;
      if (bus.s0_req) begin
        bus.s0_found   <= s0_hit;
        bus.s0_index   <= s0_idx;
        bus.s0_ps      <= s0_hit ? s0_ent.ps : '0;
        bus.s0_phytran <= s0_hit ? s0_half : '0;
      end
      if (bus.s1_req) begin
        bus.s1_found   <= s1_hit;
        bus.s1_index   <= s1_idx;
        bus.s1_ps      <= s1_hit ? s1_ent.ps : '0;
        bus.s1_phytran <= s1_hit ? s1_half : '0;
      end
      bus.s1e <= bus.s1_req && bus.s1_srch;
      if (bus.s1_req && bus.s1_srch) bus.s1_ne <= ~s1_hit;
      bus.re <= bus.rd_req;
      if (bus.rd_req) begin
        bus.r_ps       <= r_ent.ps;
        bus.r_asid     <= r_ent.asid;
        bus.r_ne       <= ~r_ent.e;
        bus.r_g        <= r_ent.g;
        bus.r_vppn     <= r_ent.vppn;
        bus.r_phytran0 <= r_ent.phytran0;
        bus.r_phytran1 <= r_ent.phytran1;
      end
      bus.inv_err <= bus.inv_en && (bus.inv_op > INV_GASID_VA);
    end
  end

endmodule

// File: tb/tb_tlb_unit.sv
// Directed plus randomized check of tlb_unit against a page-arithmetic reference model.
module tb_tlb_unit;
  import cpuDefine::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tlb_unit_if #(.TLBNUMSIZE(4)) bus ();

  tlb_unit #(.TLBNUM(16), .TLBNUMSIZE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit        e;
    bit [18:0] vppn;
    bit [5:0]  ps;
    bit        g;
    bit [9:0]  asid;
    bit [25:0] p0;
    bit [25:0] p1;
  } ment_t;

  ment_t mdl [16];
  int    n_cmp = 0;
  int    n_err = 0;
  bit [18:0] pool [4] = '{19'h00010, 19'h00200, 19'h12345, 19'h7FE00};

  bit        x_s0_found, x_s1_found, x_s1e, x_s1_ne, x_re, x_r_ne, x_r_g, x_inv_err;
  bit [3:0]  x_s0_idx, x_s1_idx;
  bit [5:0]  x_s0_ps, x_s1_ps, x_r_ps;
  bit [25:0] x_s0_ph, x_s1_ph, x_r_p0, x_r_p1;
  bit [9:0]  x_r_asid;
  bit [18:0] x_r_vppn;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // An entry maps a 2^(ps+1)-byte pair of pages; compare the va above that span.
  function automatic bit page_hit(int i, bit [31:0] va);
    int sh;
    sh = int'(mdl[i].ps) + 1;
    return (({mdl[i].vppn, 13'b0} >> sh) == (va >> sh));
  endfunction

  task automatic mdl_lookup(input bit [31:0] va, input bit [9:0] asid, output bit f,
                            output bit [3:0] idx, output bit [5:0] ps, output bit [25:0] ph);
    f = 0; idx = 0; ps = 0; ph = 0;
    for (int i = 0; i < 16; i++) begin
      if (!f && mdl[i].e && (mdl[i].g || mdl[i].asid == asid) && page_hit(i, va)) begin
        f   = 1;
        idx = 4'(i);
        ps  = mdl[i].ps;
        ph  = va[mdl[i].ps] ? mdl[i].p1 : mdl[i].p0;
      end
    end
  endtask

  task automatic step();
    bit f; bit [3:0] idx; bit [5:0] ps; bit [25:0] ph;
    bit kill, gm, am, vm;
    if (reset) begin
      foreach (mdl[i]) mdl[i] = '{default: 0};
      x_s0_found = 0; x_s0_idx = 0; x_s0_ps = 0; x_s0_ph = 0;
      x_s1_found = 0; x_s1_idx = 0; x_s1_ps = 0; x_s1_ph = 0;
      x_s1e = 0; x_s1_ne = 1; x_re = 0; x_r_ne = 1; x_r_g = 0;
      x_r_ps = 0; x_r_asid = 0; x_r_vppn = 0; x_r_p0 = 0; x_r_p1 = 0; x_inv_err = 0;
    end else begin
      if (bus.s0_req) begin
        mdl_lookup(bus.s0_va, bus.s0_asid, f, idx, ps, ph);
        x_s0_found = f; x_s0_idx = idx; x_s0_ps = ps; x_s0_ph = ph;
      end
      if (bus.s1_req) begin
        mdl_lookup(bus.s1_va, bus.s1_asid, f, idx, ps, ph);
        x_s1_found = f; x_s1_idx = idx; x_s1_ps = ps; x_s1_ph = ph;
        if (bus.s1_srch) x_s1_ne = !f;
      end
      x_s1e = bus.s1_req && bus.s1_srch;
      x_re  = bus.rd_req;
      if (bus.rd_req) begin
        x_r_ps = mdl[bus.r_index].ps;     x_r_asid = mdl[bus.r_index].asid;
        x_r_ne = !mdl[bus.r_index].e;     x_r_g    = mdl[bus.r_index].g;
        x_r_vppn = mdl[bus.r_index].vppn; x_r_p0   = mdl[bus.r_index].p0;
        x_r_p1 = mdl[bus.r_index].p1;
      end
      x_inv_err = bus.inv_en && (bus.inv_op > 6);
      if (bus.inv_en) begin
        for (int i = 0; i < 16; i++) begin
          gm = mdl[i].g;
          am = (mdl[i].asid == bus.f_asid);
          vm = page_hit(i, {bus.f_va, 13'b0});
          case (int'(bus.inv_op))
            0, 1:    kill = 1;
            2:       kill = gm;
            3:       kill = !gm;
            4:       kill = !gm && am;
            5:       kill = !gm && am && vm;
            6:       kill = (gm || am) && vm;
            default: kill = 0;
          endcase
          if (kill) mdl[i].e = 0;
        end
      end
      if (bus.we) begin
        mdl[bus.w_index].e    = !bus.w_ne;
        mdl[bus.w_index].vppn = bus.w_vppn;
        mdl[bus.w_index].ps   = bus.w_ps;
        mdl[bus.w_index].g    = bus.w_g;
        mdl[bus.w_index].asid = bus.w_asid;
        mdl[bus.w_index].p0   = bus.w_phytran0;
        mdl[bus.w_index].p1   = bus.w_phytran1;
      end
    end
    @(posedge clk);
    #1;
    check("s0_found", bus.s0_found, x_s0_found);
    check("s0_index", bus.s0_index, x_s0_idx);
    check("s0_ps", bus.s0_ps, x_s0_ps);
    check("s0_phytran", bus.s0_phytran, x_s0_ph);
    check("s1_found", bus.s1_found, x_s1_found);
    check("s1_index", bus.s1_index, x_s1_idx);
    check("s1_ps", bus.s1_ps, x_s1_ps);
    check("s1_phytran", bus.s1_phytran, x_s1_ph);
    check("s1e", bus.s1e, x_s1e);
    check("s1_ne", bus.s1_ne, x_s1_ne);
    check("re", bus.re, x_re);
    check("r_ps", bus.r_ps, x_r_ps);
    check("r_asid", bus.r_asid, x_r_asid);
    check("r_ne", bus.r_ne, x_r_ne);
    check("r_g", bus.r_g, x_r_g);
    check("r_vppn", bus.r_vppn, x_r_vppn);
    check("r_phytran0", bus.r_phytran0, x_r_p0);
    check("r_phytran1", bus.r_phytran1, x_r_p1);
    check("inv_err", bus.inv_err, x_inv_err);
  endtask

  task automatic clr();
    bus.s0_req = 0; bus.s0_va = 0; bus.s0_asid = 0;
    bus.s1_req = 0; bus.s1_srch = 0; bus.s1_va = 0; bus.s1_asid = 0;
    bus.rd_req = 0; bus.r_index = 0;
    bus.we = 0; bus.w_index = 0; bus.w_ps = 0; bus.w_ne = 0; bus.w_asid = 0;
    bus.w_vppn = 0; bus.w_g = 0; bus.w_phytran0 = '0; bus.w_phytran1 = '0;
    bus.inv_en = 0; bus.inv_op = 0; bus.f_asid = 0; bus.f_va = 0;
  endtask

  task automatic wr(input bit [3:0] idx, input bit [18:0] vppn, input bit [5:0] ps,
                    input bit g, input bit [9:0] asid, input bit [25:0] p0, input bit [25:0] p1);
    bus.we = 1; bus.w_index = idx; bus.w_vppn = vppn; bus.w_ps = ps; bus.w_g = g;
    bus.w_asid = asid; bus.w_ne = 0; bus.w_phytran0 = p0; bus.w_phytran1 = p1;
  endtask

  task automatic look0(input bit [31:0] va, input bit [9:0] asid);
    bus.s0_req = 1; bus.s0_va = va; bus.s0_asid = asid;
  endtask

  function automatic bit [18:0] rnd_vppn();
    bit [18:0] v;
    v = pool[$urandom_range(0, 3)];
    if ($urandom_range(0, 3) == 0) v[8:0] = 9'($urandom);
    return v;
  endfunction

  initial begin
    clr();
    reset = 1;
    step();
    step();
    reset = 0;

    // Search on an empty table
    bus.s1_req = 1; bus.s1_srch = 1; bus.s1_va = 32'h0000_1000;
    step();
    check("t1_s1e", bus.s1e, 1);
    check("t1_s1_ne", bus.s1_ne, 1);
    check("t1_s1_index", bus.s1_index, 0);
    clr(); step();

    // 4K entry at index 3, odd half selected by va[12]
    wr(3, 19'h00010, 12, 0, 5, 26'h0, {20'hABCDE, 6'b000001});
    step(); clr();
    look0(32'h0002_1000, 5); step();
    check("t2_found", bus.s0_found, 1);
    check("t2_index", bus.s0_index, 3);
    check("t2_ppn", bus.s0_phytran.ppn, 20'hABCDE);
    look0(32'h0002_1000, 6); step();
    check("t2_asid_miss", bus.s0_found, 0);
    clr();

    // 2M global entry at index 7, even half
    wr(7, 19'h00200, 21, 1, 0, {20'h12345, 6'b000011}, 26'h0);
    step(); clr();
    look0(32'h0040_0000, 10'h2AA); step();
    check("t3_found", bus.s0_found, 1);
    check("t3_index", bus.s0_index, 7);
    check("t3_ppn", bus.s0_phytran.ppn, 20'h12345);
    clr(); bus.rd_req = 1; bus.r_index = 7; step();
    check("t3_re", bus.re, 1);
    check("t3_r_g", bus.r_g, 1);
    check("t3_r_ps", bus.r_ps, 21);
    check("t3_r_ne", bus.r_ne, 0);
    clr();

    // INVTLB by G
    bus.inv_en = 1; bus.inv_op = 3; step(); clr();
    look0(32'h0002_1000, 5); step();
    check("t4_g0_gone", bus.s0_found, 0);
    look0(32'h0040_0000, 5); step();
    check("t4_g1_kept", bus.s0_found, 1);
    clr(); bus.inv_en = 1; bus.inv_op = 2; step(); clr();
    look0(32'h0040_0000, 5); step();
    check("t4_g1_gone", bus.s0_found, 0);
    clr(); bus.inv_en = 1; bus.inv_op = 9; step();
    check("t4_inv_err", bus.inv_err, 1);
    clr(); step();
    check("t4_inv_err_end", bus.inv_err, 0);

    // Write + flush-all in one cycle; a lookup in that cycle sees the old table
    wr(3, 19'h00010, 12, 0, 5, 26'h0, {20'hABCDE, 6'b000001}); step(); clr();
    wr(2, 19'h12345, 12, 1, 0, 26'h15, 26'h2A);
    bus.inv_en = 1; bus.inv_op = 0;
    look0(32'h0002_1000, 5); step();
    check("t5_old_view", bus.s0_found, 1);
    check("t5_old_index", bus.s0_index, 3);
    clr();
    for (int i = 0; i < 16; i++) begin
      bus.rd_req = 1; bus.r_index = 4'(i); step();
      check("t5_only_2", bus.r_ne, (i == 2) ? 0 : 1);
    end
    clr();

    // Overlapping hits, lowest index wins; then reset cancels a lookup
    wr(4, 19'h7FE00, 12, 1, 0, 26'h1, 26'h2); step();
    wr(1, 19'h7FE00, 12, 1, 0, 26'h3, 26'h4); step(); clr();
    look0({19'h7FE00, 13'h0}, 1); step();
    check("t6_prio", bus.s0_index, 1);
    reset = 1; step();
    check("t6_reset", bus.s0_found, 0);
    reset = 0; clr(); step();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bus.s0_req  = $urandom_range(0, 3) != 0;
      bus.s0_va   = {rnd_vppn(), 13'($urandom)};
      bus.s0_asid = 10'($urandom_range(1, 3));
      bus.s1_req  = $urandom_range(0, 3) != 0;
      bus.s1_srch = 1'($urandom_range(0, 1));
      bus.s1_va   = {rnd_vppn(), 13'($urandom)};
      bus.s1_asid = 10'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        bus.s1_va = bus.s0_va; bus.s1_asid = bus.s0_asid;
      end
      bus.rd_req     = $urandom_range(0, 2) == 0;
      bus.r_index    = 4'($urandom);
      bus.we         = $urandom_range(0, 2) == 0;
      bus.w_index    = 4'($urandom);
      bus.w_ps       = $urandom_range(0, 1) ? 6'd12 : 6'd21;
      bus.w_ne       = $urandom_range(0, 4) == 0;
      bus.w_asid     = 10'($urandom_range(1, 3));
      bus.w_vppn     = rnd_vppn();
      bus.w_g        = $urandom_range(0, 3) == 0;
      bus.w_phytran0 = 26'($urandom);
      bus.w_phytran1 = 26'($urandom);
      bus.inv_en     = $urandom_range(0, 15) == 0;
      bus.inv_op     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
      bus.f_asid     = 10'($urandom_range(1, 3));
      bus.f_va       = rnd_vppn();
      reset          = $urandom_range(0, 199) == 0;
      step();
    end
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tlb_unit.md
Name: tlb_unit

Overview:
- Translation table that answers the CSR file's TLB requests: TLBSRCH search, TLBRD read, TLBWR/TLBFILL write and INVTLB flush.
- Also serves two lookup ports: port 0 for instruction fetch and port 1 for memory access and TLBSRCH.
- Entries are held in flops. Lookup and read results are registered, one cycle after the request.

Parameters:
- TLBNUM, 16, number of entries (power of two).
- TLBNUMSIZE, 4, index width, log2(TLBNUM); matches the cpuDefine constant.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s0_req  in  1  fetch lookup valid
- s0_va  in  32  fetch virtual address
- s0_asid  in  10  current ASID
- s0_found  out  1  hit, registered
- s0_index  out  TLBNUMSIZE  hit index
- s0_ps  out  6  page size of hit
- s0_phytran  out  PhytranItem  selected odd/even half
- s1_req  in  1  data lookup valid
- s1_srch  in  1  request is a TLBSRCH (qualifies s1_req)
- s1_va  in  32  data virtual address
- s1_asid  in  10  current ASID
- s1_found  out  1  hit
- s1_ps  out  6  page size of hit
- s1_phytran  out  PhytranItem  selected half
- s1e  out  1  TLBSRCH result strobe to CSR
- s1_index  out  TLBNUMSIZE  hit index
- s1_ne  out  1  not-found flag
- rd_req  in  1  TLBRD issue
- r_index  in  TLBNUMSIZE  entry to read
- re  out  1  read-result strobe
- r_ps  out  6  entry page size
- r_asid  out  10  entry ASID
- r_ne  out  1  entry not exist
- r_g  out  1  entry global bit
- r_vppn  out  19  entry VPPN
- r_phytran0  out  PhytranItem  entry even half
- r_phytran1  out  PhytranItem  entry odd half
- we  in  1  write strobe
- w_index, w_ps, w_ne, w_asid, w_vppn, w_g, w_phytran0, w_phytran1  in  as r_*  write data
- inv_en  in  1  INVTLB strobe
- inv_op  in  5  INVTLB op
- f_asid  in  10  flush ASID
- f_va  in  19  flush VPPN
- inv_err  out  1  illegal op pulse

Behaviour:
- Entry contents: E (=~ne), VPPN[18:0], PS[5:0], G, ASID[9:0], phytran0, phytran1. PhytranItem = {PPN[19:0], PLV[1:0], MAT[1:0], D, V}.
- Reset: all E cleared, all other entry fields cleared. Every output reads 0 in the cycle after reset, except s1_ne=1 and r_ne=1.
- Match rule, entry i vs va/asid: E && (G || ASID==asid) && (PS==12 ? VPPN==va[31:13] : VPPN[18:9]==va[31:22]).
- Half select: PS==12 ? va[12] : va[21]; 1 selects phytran1.
- Lookup ports: combinational compare on cycle N, outputs registered and valid at N+1.
  - Multiple hits: the lowest index wins.
  - No hit: found=0, index/ps/phytran=0.
  - Outputs hold their value when req=0.
- s1e: a 1-cycle pulse at N+1 when s1_req&&s1_srch at N. s1_ne=~found on that same cycle.
- Read: rd_req at N gives re=1 for 1 cycle at N+1, with r_* = entry[r_index] as it stood at N. r_ne=~E. Fields are returned even when E=0.
- Write: on we, entry[w_index] is updated at the clock edge with E=~w_ne. Lookups and reads in the same cycle see the old contents.
- INVTLB: takes effect at the edge; each matched entry has E cleared.
  - op 0, 1: all entries.
  - op 2: G=1.
  - op 3: G=0.
  - op 4: G=0 and ASID==f_asid.
  - op 5: G=0, ASID==f_asid and VPPN matches f_va (PS-aware, as in the match rule).
  - op 6: (G=1 or ASID==f_asid) and VPPN matches f_va.
  - op >6: no entry change; inv_err=1 for 1 cycle.
- Simultaneous we and inv_en: invalidation is evaluated on the old contents, then the write is applied. The written entry always survives.
- Simultaneous lookup on both ports with the same va: independent, both ports report identically.
- Reset mid-operation: pending registered results are discarded and s1e/re/inv_err go to 0.

Decomposition:
- cpuDefine package holds:
  - TLBNUMSIZE
  - PhytranItem
  - TlbEntry struct
  - INVTLB op localparams (INV_ALL0, INV_ALL1, INV_G1, INV_G0, INV_ASID, INV_ASID_VA, INV_GASID_VA)
- Sub-module tlb_match: one compare port producing a TLBNUM-bit hit vector plus the priority-encoded index. It is instantiated twice, once per lookup port. The INVTLB VA compare reuses the same match function, defined in the package.

Test Plan:
1. Reset, then s1_req+s1_srch with va=0x0000_1000 -> next cycle s1e=1, s1_ne=1, s1_index=0.
2. Write index 3: vppn=0x00010, ps=12, asid=5, G=0, phytran1.PPN=0xABCDE, V=1. Then s0_req va=0x0002_1000, asid=5 -> s0_found=1, s0_index=3, s0_phytran.PPN=0xABCDE. Same va with asid=6 -> found=0.
3. Write index 7: ps=21, G=1, vppn=0x00200. Lookup va=0x0040_0000, any asid -> hit idx 7, half even. rd_req r_index=7 -> re=1, r_g=1, r_ps=21, r_ne=0.
4. With entries 3 (G=0, asid 5) and 7 (G=1): inv_op=3 -> entry 3 gone, 7 kept. inv_op=2 -> 7 gone. inv_op=9 -> inv_err pulse, contents unchanged.
5. Same cycle: we to index 2 and inv_op=0 -> only index 2 valid afterwards. A lookup issued in that cycle sees the pre-write contents.
6. Entries 1 and 4 both match va -> s0_index=1; overlapping reset mid-lookup -> s0_found=0 next cycle.
